alu_seq: RTL and testbench

//  Registered, handshaked successor to the combinational ALU. Width is parametrised.

---
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered, handshaked ALU: one op in flight, non-MUL ops complete in one cycle, MUL iterates WIDTH cycles.
// The {V,C,N,Z} flag register persists between ops and supplies the carry-in for ADC.
module alu_seq #(
  parameter int WIDTH  = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_ASR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_ADC = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               accept, is_mul, shift_big;
  logic               alu_legal, alu_c, alu_v, cin;
  logic [WIDTH-1:0]   alu_res, addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = MUL_EN && (op == OP_MUL);
  assign shift_big = (b >= WIDTH'(WIDTH));

  // SUB/CMP reuse the adder as a + ~b + 1, so C comes out as no-borrow.
  always_comb begin
    addend = b;
    cin    = 1'b0;
    if (op == OP_SUB || op == OP_CMP) begin
      addend = ~b;
      cin    = 1'b1;
    end else if (op == OP_ADC) begin
      cin = flags_q[2];
    end
  end

  assign sum = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_legal = 1'b1;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_CMP: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_SLL:  alu_res = shift_big ? '0 : (a << b);
      OP_SRL:  alu_res = shift_big ? '0 : (a >> b);
      OP_ASR:  alu_res = shift_big ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> b);
      default: alu_legal = 1'b0;
    endcase
  end

  // One shift-add step per EXEC cycle, LSB of the multiplier first.
  assign acc_next = acc_q + (mplier_q[cnt_q] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_EXEC: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = acc_next[WIDTH-1:0];
          flags_d  = {1'b0, |acc_next[2*WIDTH-1:WIDTH], acc_next[WIDTH-1],
                      acc_next[WIDTH-1:0] == '0};
        end
      end
      default: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = S_EXEC;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            if (alu_legal) begin
              flags_d = {alu_v, alu_c, alu_res[WIDTH-1], alu_res == '0};
            end
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=4, MUL_EN=1): reference model pushes expectations on accept,
// the output monitor pops and compares on every out_valid&out_ready handshake.
module tb_alu_seq;
  localparam int W = 4;

  typedef struct {
    logic [3:0] res;
    logic [3:0] flg;
    int         op;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int   n_chk = 0;
  int   n_err = 0;
  logic [3:0] mflg = '0;
  bit   rnd_rdy = 1'b0;
  exp_t sb[$];

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference model on plain integers; updates the model flag register for legal ops.
  function automatic logic [3:0] model(input int o, input int x, input int y);
    int r, sx, sy, sv, ci;
    logic c, v, legal;
    r = 0; sv = 0; ci = 0; c = 1'b0; legal = 1'b1;
    sx = (x >= 8) ? x - 16 : x;
    sy = (y >= 8) ? y - 16 : y;
    case (o)
      0:     begin r = x + y; c = (r > 15); sv = sx + sy; end
      1, 11: begin r = x - y; c = (x >= y); sv = sx - sy; end
      2:     r = x & y;
      3:     r = x | y;
      4:     r = x ^ y;
      5:     r = 15 - x;
      6:     r = (y >= 4) ? 0 : (x << y);
      7:     r = x >> y;
      8:     r = (y >= 4) ? ((x >= 8) ? 15 : 0) : (sx >>> y);
      9:     begin r = x * y; c = (r > 15); end
      10:    begin ci = int'(mflg[2]); r = x + y + ci; c = (r > 15); sv = sx + sy + ci; end
      default: begin r = 0; legal = 1'b0; end
    endcase
    v = (sv > 7) || (sv < -8);
    r = r & 15;
    if (legal) mflg = {v, c, r[3], r == 0};
    return r[3:0];
  endfunction

  task automatic issue(input int o, input int x, input int y);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; op = 4'(o); a = W'(x); b = W'(y);
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      #1;
      n++;
    end
    chk("accept", 32'(in_ready), 32'd1);
    if (in_ready) begin
      e.res = model(o, x, y);
      e.flg = mflg;
      e.op  = o;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("res_op%0d", e.op), 32'(result), 32'(e.res));
        chk($sformatf("flg_op%0d", e.op), 32'(flags), 32'(e.flg));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovld", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_flg", 32'(flags), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    issue(0, 7, 9);
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("lat_add", 32'(lat), 32'd1);
    issue(0, 7, 1);
    issue(1, 3, 5);

    issue(9, 6, 5);
    chk("mul_busy", 32'(busy), 32'd1);
    chk("mul_irdy", 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("lat_mul", 32'(lat), 32'd5);
    issue(9, 5, 3);

    // ADC right behind ADD must see the carry of the op retiring that same cycle.
    issue(0, 15, 1);
    issue(10, 2, 3);
    issue(8, 8, 5);
    issue(6, 3, 4);
    issue(8, 12, 1);
    issue(7, 12, 2);
    issue(2, 12, 10);
    issue(3, 5, 2);
    issue(5, 5, 0);
    issue(11, 5, 9);
    issue(12, 3, 3);
    issue(10, 1, 1);
    issue(15, 9, 9);
    issue(0, 8, 8);
    issue(10, 7, 0);

    // Operands are captured at acceptance, even while MUL is still iterating.
    issue(9, 7, 3);
    a = 4'h0; b = 4'hF; op = 4'd1;
    drain();

    @(negedge clk);
    out_ready = 1'b0;
    issue(4, 5, 3);
    for (int i = 0; i < 3; i++) begin
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_irdy", 32'(in_ready), 32'd0);
      chk("bp_res", 32'(result), 32'h6);
      chk("bp_flg", 32'(flags), 32'h0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    issue(9, 7, 7);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstm_ovld", 32'(out_valid), 32'd0);
    chk("rstm_flg", 32'(flags), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    sb.delete();
    mflg = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rstm_noemit", 32'(out_valid), 32'd0);
    chk("rstm_idle", 32'(busy), 32'd0);
    issue(10, 2, 3);
    drain();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    rnd_rdy = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
